// File: rtl/cpu4_pkg.sv
// cpu4_pkg: opcode encodings and sequencer state encoding shared by the 4-bit processor
package cpu4_pkg;
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_LDB  = 4'h6;
   localparam logic [3:0] OP_JMP  = 4'h7;
   localparam logic [3:0] OP_JZ   = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;
   typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_HALT} state_t;
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction-memory and ALU bus between the sequencer (master) and memory/ALU (slave)
//   imem_addr/imem_data: instruction fetch; alu_a/alu_b/alu_opcode -> ALU, alu_result/alu_zero <- ALU
interface alu_sequencer_if #(parameter int PC_W = 4);
   logic [PC_W-1:0] imem_addr;
   logic [7:0]      imem_data;
   logic [3:0]      alu_a;
   logic [3:0]      alu_b;
   logic [3:0]      alu_opcode;
   logic [3:0]      alu_result;
   logic            alu_zero;
   modport master (output imem_addr, alu_a, alu_b, alu_opcode, input imem_data, alu_result, alu_zero);
   modport slave (input imem_addr, alu_a, alu_b, alu_opcode, output imem_data, alu_result, alu_zero);
endinterface

// File: rtl/seq_decoder.sv
// seq_decoder: combinational opcode decode into writeback/branch/halt controls
//   op in: IR[7:4]; outputs: is_alu, wr_acc, wr_b, wr_z, is_jmp, is_jz, is_halt (undefined ops decode to none)
module seq_decoder
   import cpu4_pkg::*;
(
   input  logic [3:0] op,
   output logic       is_alu,
   output logic       wr_acc,
   output logic       wr_b,
   output logic       wr_z,
   output logic       is_jmp,
   output logic       is_jz,
   output logic       is_halt
);
   always_comb begin
      is_alu  = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
      wr_acc  = is_alu || op == OP_LDI;
      wr_z    = is_alu || op == OP_LDI;
      wr_b    = op == OP_LDB;
      is_jmp  = op == OP_JMP;
      is_jz   = op == OP_JZ;
      is_halt = op == OP_HALT;
   end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/decode/execute control unit for the 4-bit processor
//   clk, rst_n (async active-low), run (start level in IDLE), bus (master: imem fetch + ALU drive),
//   acc_out/zflag_out (ACC, Z), halted (HALT state), busy (FETCH/DECODE/EXECUTE)
module alu_sequencer
   import cpu4_pkg::*;
#(
   parameter int              PC_W     = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  run,
   alu_sequencer_if.master       bus,
   output logic [3:0]            acc_out,
   output logic                  zflag_out,
   output logic                  halted,
   output logic                  busy
);
   typedef logic [PC_W-1:0] pc_t;
   state_t     state_q, state_d;
   pc_t        pc_q, pc_d, addr_q, addr_d;
   logic [7:0] ir_q, ir_d;
   logic [3:0] acc_q, acc_d, b_q, b_d, imm;
   logic       z_q, z_d;
   logic       is_alu, wr_acc, wr_b, wr_z, is_jmp, is_jz, is_halt;
   assign imm = ir_q[3:0];
   seq_decoder u_dec (
      .op      (ir_q[7:4]),
      .is_alu  (is_alu),
      .wr_acc  (wr_acc),
      .wr_b    (wr_b),
      .wr_z    (wr_z),
      .is_jmp  (is_jmp),
      .is_jz   (is_jz),
      .is_halt (is_halt)
   );
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      ir_d    = ir_q;
      acc_d   = acc_q;
      b_d     = b_q;
      z_d     = z_q;
      case (state_q)
         ST_IDLE: begin
            state_d = run ? ST_FETCH : ST_IDLE;
            pc_d    = run ? RESET_PC : pc_q;
            addr_d  = run ? RESET_PC : addr_q;
         end
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            ir_d    = bus.imem_data;
            pc_d    = pc_q + pc_t'(1);
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            acc_d   = wr_acc ? (is_alu ? bus.alu_result : imm) : acc_q;
            z_d     = wr_z ? (is_alu ? bus.alu_zero : imm == 4'd0) : z_q;
            b_d     = wr_b ? imm : b_q;
            pc_d    = (is_jmp || (is_jz && z_q)) ? pc_t'(imm) : pc_q;
            state_d = is_halt ? ST_HALT : ST_FETCH;
            addr_d  = is_halt ? addr_q : pc_d;
         end
         default: state_d = ST_HALT;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         ir_q    <= '0;
         acc_q   <= '0;
         b_q     <= '0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         ir_q    <= ir_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         z_q     <= z_d;
      end
   end
   assign bus.imem_addr  = addr_q;
   assign bus.alu_a      = acc_q;
   assign bus.alu_b      = b_q;
   assign bus.alu_opcode = (state_q == ST_EXEC && is_alu) ? ir_q[7:4] : OP_NOP;
   assign acc_out        = acc_q;
   assign zflag_out      = z_q;
   assign halted         = state_q == ST_HALT;
   assign busy           = state_q inside {ST_FETCH, ST_DECODE, ST_EXEC};
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed programs on sequencer + ALU model + 16x8 ROM, with an expected-result scoreboard
module tb_alu_sequencer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic [3:0] acc_out;
   logic       zflag_out, halted, busy;
   logic [7:0] rom [16];
   int         total = 0;
   int         fails = 0;
   typedef struct { string tag; logic [3:0] acc; logic z; } exp_t;
   exp_t       sb[$];
   alu_sequencer_if #(.PC_W(4)) bus ();
   alu_sequencer #(.PC_W(4), .RESET_PC(4'd0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .bus       (bus),
      .acc_out   (acc_out),
      .zflag_out (zflag_out),
      .halted    (halted),
      .busy      (busy)
   );
   always #5 clk = ~clk;
   always_ff @(posedge clk) bus.imem_data <= rom[bus.imem_addr];
   always_comb begin
      case (bus.alu_opcode)
         4'h2:    bus.alu_result = bus.alu_a + bus.alu_b;
         4'h3:    bus.alu_result = bus.alu_a - bus.alu_b;
         4'h4:    bus.alu_result = bus.alu_a & bus.alu_b;
         4'h5:    bus.alu_result = bus.alu_a | bus.alu_b;
         default: bus.alu_result = bus.alu_a;
      endcase
      bus.alu_zero = bus.alu_result == 4'd0;
   end
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic clear_rom();
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
   endtask
   task automatic start();
      rst_n = 1'b0;
      run = 1'b0;
      #2;
      @(negedge clk);
      rst_n = 1'b1;
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
   endtask
   task automatic wait_halt(input int budget, output int cyc);
      cyc = 1;
      while (!halted && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
   endtask
   task automatic score();
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "_halted"}, {7'd0, halted}, 8'd1);
      chk({e.tag, "_acc"}, {4'd0, acc_out}, {4'd0, e.acc});
      chk({e.tag, "_z"}, {7'd0, zflag_out}, {7'd0, e.z});
   endtask
   initial begin
      int cyc;
      int n;
      clear_rom();
      #3;
      chk("rst_acc", {4'd0, acc_out}, 8'd0);
      chk("rst_z", {7'd0, zflag_out}, 8'd0);
      chk("rst_halted", {7'd0, halted}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_addr", {4'd0, bus.imem_addr}, 8'd0);
      chk("rst_opc", {4'd0, bus.alu_opcode}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_no_run_busy", {7'd0, busy}, 8'd0);
      // LDI 3, LDB 5, ADD, HALT
      clear_rom();
      rom[0] = 8'h13; rom[1] = 8'h65; rom[2] = 8'h20; rom[3] = 8'hF0;
      sb.push_back('{"add38", 4'd8, 1'b0});
      start();
      wait_halt(40, cyc);
      chk("add38_cycles", 8'(cyc), 8'd13);
      chk("add38_busy", {7'd0, busy}, 8'd0);
      score();
      run = 1'b1;
      repeat (5) @(negedge clk);
      run = 1'b0;
      chk("halt_ignores_run", {7'd0, halted}, 8'd1);
      // 9 + 9 wraps to 2
      clear_rom();
      rom[0] = 8'h19; rom[1] = 8'h69; rom[2] = 8'h20; rom[3] = 8'hF0;
      sb.push_back('{"add99", 4'd2, 1'b0});
      start();
      wait_halt(40, cyc);
      score();
      // 8 + 8 wraps to 0 and sets Z
      rom[0] = 8'h18; rom[1] = 8'h68;
      sb.push_back('{"add88", 4'd0, 1'b1});
      start();
      wait_halt(40, cyc);
      score();
      // SUB to zero, JZ taken to address 6
      clear_rom();
      rom[0] = 8'h15; rom[1] = 8'h65; rom[2] = 8'h30; rom[3] = 8'h86;
      rom[4] = 8'h11; rom[5] = 8'hF0; rom[6] = 8'h17; rom[7] = 8'hF0;
      sb.push_back('{"jz_taken", 4'd7, 1'b0});
      start();
      wait_halt(60, cyc);
      score();
      // nonzero difference: JZ falls through to LDI 1
      rom[1] = 8'h64;
      sb.push_back('{"jz_not", 4'd1, 1'b0});
      start();
      wait_halt(60, cyc);
      score();
      // all-NOP ROM beyond address 0: PC wraps and re-executes LDI 2 forever
      clear_rom();
      rom[0] = 8'h12;
      start();
      n = 0;
      while (bus.imem_addr !== 4'd15 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("wrap_addr15", {4'd0, bus.imem_addr}, 8'd15);
      n = 0;
      while (bus.imem_addr !== 4'd0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("wrap_addr0", {4'd0, bus.imem_addr}, 8'd0);
      repeat (60) @(negedge clk);
      chk("wrap_acc", {4'd0, acc_out}, 8'd2);
      chk("wrap_halted", {7'd0, halted}, 8'd0);
      chk("wrap_busy", {7'd0, busy}, 8'd1);
      // async reset during EXECUTE of ADD
      clear_rom();
      rom[0] = 8'h13; rom[1] = 8'h65; rom[2] = 8'h20; rom[3] = 8'hF0;
      start();
      repeat (8) @(negedge clk);
      chk("exec_add_opc", {4'd0, bus.alu_opcode}, 8'h02);
      chk("exec_add_b", {4'd0, bus.alu_b}, 8'd5);
      chk("exec_add_acc", {4'd0, acc_out}, 8'd3);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_acc", {4'd0, acc_out}, 8'd0);
      chk("arst_b", {4'd0, bus.alu_b}, 8'd0);
      chk("arst_z", {7'd0, zflag_out}, 8'd0);
      chk("arst_busy", {7'd0, busy}, 8'd0);
      chk("arst_opc", {4'd0, bus.alu_opcode}, 8'd0);
      // undefined opcode 0xA3 behaves as NOP
      clear_rom();
      rom[0] = 8'h14; rom[1] = 8'hA3; rom[2] = 8'hF0;
      sb.push_back('{"undef", 4'd4, 1'b0});
      start();
      repeat (5) @(negedge clk);
      chk("undef_exec_opc", {4'd0, bus.alu_opcode}, 8'd0);
      chk("undef_exec_busy", {7'd0, busy}, 8'd1);
      wait_halt(40, cyc);
      score();
      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
